molecule_motion_ctrl: RTL



---
 rtl/molecule_motion_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/molecule_motion_ctrl.sv
// Per-molecule motion engine: steps a 16-px sprite once per frame, bouncing off screen edges
// and off the membrane band. Optional macro CROSS_COUNT_EN adds a saturating side-crossing counter.
module molecule_motion_ctrl #(
  parameter logic [9:0] INIT_X   = 10'd100,
  parameter logic [9:0] INIT_Y   = 10'd100,
  parameter logic       INIT_DX  = 1'b1,
  parameter logic       INIT_DY  = 1'b1,
  parameter logic [9:0] STEP     = 10'd2,
  parameter logic [9:0] MOL_SIZE = 10'd16,
  parameter logic [9:0] X_MAX    = 10'd640,
  parameter logic [9:0] Y_MAX    = 10'd480,
  parameter logic [9:0] MEMB_X   = 10'd316,
  parameter logic [9:0] MEMB_W   = 10'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame,
  input  logic       magenta_membrane,
  input  logic       red_membrane,
  input  logic       blue_membrane,
  input  logic       no_membrane,
  input  logic       membrane_on,
  input  logic       is_red,
  input  logic       freeze,
  input  logic       btnD,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
`ifdef CROSS_COUNT_EN
  output logic [7:0] cross_cnt,
`endif
  output logic       side
);

  localparam logic [10:0] STEP_W   = {1'b0, STEP};
  localparam logic [10:0] SIZE_W   = {1'b0, MOL_SIZE};
  localparam logic [10:0] X_LIM    = {1'b0, X_MAX} - SIZE_W;
  localparam logic [10:0] Y_LIM    = {1'b0, Y_MAX} - SIZE_W;
  localparam logic [10:0] BAND_L   = {1'b0, MEMB_X};
  localparam logic [10:0] BAND_R   = {1'b0, MEMB_X} + {1'b0, MEMB_W};
  localparam logic [10:0] HALF_SZ  = {2'b00, MOL_SIZE[9:1]};
  localparam logic [10:0] SIDE_THR = {1'b0, MEMB_X} + {2'b00, MEMB_W[9:1]};
  localparam logic        SIDE_INIT = (({1'b0, INIT_X} + HALF_SZ) >= SIDE_THR);

  typedef enum logic [1:0] {HOLD, MOVE, FROZEN} state_t;

  state_t     state_q, state_d;
  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic       side_q, side_d;
  logic       btn_q;
  logic       btn_rise, move_en;

  logic [10:0] x_cur, x_step, x_after, x_n;
  logic [10:0] y_cur, y_step, y_n;
  logic        x_under, y_under, blocked, memb_hold, dx_n, dy_n;

  function automatic logic in_band(input logic [10:0] x);
    return (x < BAND_R) && ((x + SIZE_W) > BAND_L);
  endfunction

  assign btn_rise = btnD & ~btn_q;

  // State register together with the position datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      pos_x_q <= INIT_X;
      pos_y_q <= INIT_Y;
      dx_q    <= INIT_DX;
      dy_q    <= INIT_DY;
      side_q  <= SIDE_INIT;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      side_q  <= side_d;
      btn_q   <= btnD;
    end
  end

  always_comb begin
    state_d = state_q;
    if (btn_rise) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        HOLD:    if (frame && !freeze && !btnD) state_d = MOVE;
        MOVE:    if (freeze) state_d = FROZEN;
        FROZEN:  if (!freeze) state_d = MOVE;
        default: state_d = HOLD;
      endcase
    end
  end

  always_comb begin
    move_en = (state_q == MOVE) && !btn_rise && !freeze && frame;
  end

  // Candidate step per axis; membrane hold first, then screen clamp on the result
  always_comb begin
    x_cur   = {1'b0, pos_x_q};
    y_cur   = {1'b0, pos_y_q};
    x_step  = dx_q ? (x_cur + STEP_W) : (x_cur - STEP_W);
    y_step  = dy_q ? (y_cur + STEP_W) : (y_cur - STEP_W);
    x_under = !dx_q && (x_cur < STEP_W);
    y_under = !dy_q && (y_cur < STEP_W);

    blocked   = membrane_on && !no_membrane &&
                (magenta_membrane || (red_membrane && !is_red) || (blue_membrane && is_red));
    memb_hold = blocked && !in_band(x_cur) && in_band(x_step);
    x_after   = memb_hold ? x_cur : x_step;

    x_n  = x_after;
    dx_n = dx_q ^ memb_hold;
    if (!memb_hold && x_under) begin
      x_n  = 11'd0;
      dx_n = ~dx_q;
    end else if (x_after > X_LIM) begin
      x_n  = X_LIM;
      dx_n = ~dx_n;
    end

    y_n  = y_step;
    dy_n = dy_q;
    if (y_under) begin
      y_n  = 11'd0;
      dy_n = ~dy_q;
    end else if (y_step > Y_LIM) begin
      y_n  = Y_LIM;
      dy_n = ~dy_q;
    end
  end

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (btn_rise) begin
      pos_x_d = INIT_X;
      pos_y_d = INIT_Y;
      dx_d    = INIT_DX;
      dy_d    = INIT_DY;
    end else if (move_en) begin
      pos_x_d = x_n[9:0];
      pos_y_d = y_n[9:0];
      dx_d    = dx_n;
      dy_d    = dy_n;
    end
    side_d = (({1'b0, pos_x_d} + HALF_SZ) >= SIDE_THR);
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign side  = side_q;

`ifdef CROSS_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (btn_rise) begin
      cnt_d = 8'd0;
    end else if ((side_d != side_q) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign cross_cnt = cnt_q;
`endif

endmodule
